// File: rtl/mmio_pkg.sv
// Shared address map, load/store width codes and timebase helpers for the MMIO responder.
// Store codes sit at 8 + funct3[1:0] so loads and stores share one enum.
package mmio_pkg;

  localparam logic [31:0] LED_RGB_ADDR = 32'hFFFF_FFFC;
  localparam logic [31:0] MICROS_ADDR  = 32'hFFFF_FFF8;
  localparam logic [31:0] MILLIS_ADDR  = 32'hFFFF_FFF4;
  localparam logic [31:0] SW_ADDR      = 32'hFFFF_FFF0;
  localparam logic [27:0] MMIO_PAGE    = 28'hFFF_FFFF;

  localparam int unsigned US_PER_MS = 1000;

  typedef enum logic [3:0] {
    LB  = 4'h0,
    LH  = 4'h1,
    LW  = 4'h2,
    LBU = 4'h4,
    LHU = 4'h5,
    SB  = 4'h8,
    SH  = 4'h9,
    SW  = 4'hA
  } funct3_e;

  function automatic int unsigned us_div(input int unsigned clk_hz);
    return clk_hz / 1_000_000;
  endfunction

  function automatic int unsigned ms_div(input int unsigned clk_hz);
    return clk_hz / 1000;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One RGB channel: shadow duty written by the bus, active duty reloaded at the shared counter wrap.
// Output is active-low and glitch-free because the compare only sees the active duty.
module pwm_channel #(
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                pwm_wrap,
  input  logic                duty_wr_en,
  input  logic [PWM_BITS-1:0] duty_wdata,
  output logic [PWM_BITS-1:0] duty_shadow,
  output logic                pin_n
);

  logic [PWM_BITS-1:0] shadow_q, shadow_d;
  logic [PWM_BITS-1:0] active_q, active_d;

  always_comb begin
    shadow_d = duty_wr_en ? duty_wdata : shadow_q;
    active_d = pwm_wrap ? shadow_q : active_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign duty_shadow = shadow_q;
  assign pin_n       = !(pwm_cnt < active_q);

endmodule

// File: rtl/mmio_responder.sv
// Byte-addressable LED/RGB/timer/switch registers on the core data bus; loads return after 1 cycle.
// MMIO_SW_DEBOUNCE_EN adds a 1 ms debounce after the switch synchronizer.
module mmio_responder
  import mmio_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 12_000_000,
  parameter int unsigned PWM_BITS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [2:0]  funct3,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  input  logic        SW,
  output logic        LED,
  output logic        RGB_R,
  output logic        RGB_G,
  output logic        RGB_B
);

  localparam logic [31:0] US_LAST = 32'(us_div(CLK_HZ) - 1);
  localparam logic [9:0]  MS_LAST = 10'(US_PER_MS - 1);

  logic [31:0] pre_q, pre_d, micros_q, micros_d, millis_q, millis_d;
  logic [9:0]  sub_q, sub_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic        led_q, led_d, rdata_valid_q, rdata_valid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d, sw_state;
  logic        hit, us_tick, ms_tick, pwm_wrap;
  funct3_e     ld_op, st_op;
  logic [3:0]  be;
  logic [31:0] wlane, rword, rshift, ld_val;
  logic [PWM_BITS-1:0] r_shadow, g_shadow, b_shadow;

  assign hit      = (addr[31:4] == MMIO_PAGE);
  assign ld_op    = funct3_e'({1'b0, funct3});
  // Store width ignores funct3[2], so one funct3 can carry both SB and LBU in the same cycle.
  assign st_op    = funct3_e'({2'b10, funct3[1:0]});
  assign wlane    = wdata << {addr[1:0], 3'b000};
  assign pwm_wrap = &pwm_cnt_q;

  always_comb begin
    be = 4'b0000;
    case (st_op)
      SB:           be = 4'b0001 << addr[1:0];
      SH:           if (!addr[0]) be = 4'b0011 << addr[1:0];
      mmio_pkg::SW: if (addr[1:0] == 2'b00) be = 4'b1111;
      default:      be = 4'b0000;
    endcase
    if (!(wr_en && hit && addr[3:2] == 2'b11)) be = 4'b0000;
  end

  always_comb begin
    us_tick   = (pre_q == US_LAST);
    ms_tick   = us_tick && (sub_q == MS_LAST);
    pre_d     = us_tick ? 32'd0 : pre_q + 32'd1;
    sub_d     = ms_tick ? 10'd0 : (us_tick ? sub_q + 10'd1 : sub_q);
    micros_d  = micros_q + 32'(us_tick);
    millis_d  = millis_q + 32'(ms_tick);
    pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
    led_d     = be[3] ? wlane[24] : led_q;
    sw_s1_d   = SW;
    sw_s2_d   = sw_s1_q;
  end

  always_comb begin
    case (addr[3:2])
      2'b11:   rword = {7'b0, led_q, 8'(r_shadow), 8'(g_shadow), 8'(b_shadow)};
      2'b10:   rword = micros_q;
      2'b01:   rword = millis_q;
      default: rword = {31'b0, sw_state};
    endcase
    rshift = rword >> {addr[1:0], 3'b000};
    ld_val = 32'd0;
    case (ld_op)
      LB:      ld_val = {{24{rshift[7]}}, rshift[7:0]};
      LBU:     ld_val = {24'b0, rshift[7:0]};
      LH:      if (!addr[0]) ld_val = {{16{rshift[15]}}, rshift[15:0]};
      LHU:     if (!addr[0]) ld_val = {16'b0, rshift[15:0]};
      LW:      if (addr[1:0] == 2'b00) ld_val = rword;
      default: ld_val = 32'd0;
    endcase
    if (!hit) ld_val = 32'd0;
    // rword is sampled before this edge's store commits, giving read-before-write.
    rdata_d       = rd_en ? ld_val : rdata_q;
    rdata_valid_d = rd_en;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q         <= '0;
      sub_q         <= '0;
      micros_q      <= '0;
      millis_q      <= '0;
      pwm_cnt_q     <= '0;
      led_q         <= 1'b0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      sw_s1_q       <= 1'b0;
      sw_s2_q       <= 1'b0;
    end else begin
      pre_q         <= pre_d;
      sub_q         <= sub_d;
      micros_q      <= micros_d;
      millis_q      <= millis_d;
      pwm_cnt_q     <= pwm_cnt_d;
      led_q         <= led_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      sw_s1_q       <= sw_s1_d;
      sw_s2_q       <= sw_s2_d;
    end
  end

`ifdef MMIO_SW_DEBOUNCE_EN
  localparam logic [31:0] DB_LAST = 32'(ms_div(CLK_HZ) - 1);
  logic [31:0] db_cnt_q, db_cnt_d;
  logic        sw_state_q, sw_state_d;

  always_comb begin
    db_cnt_d   = 32'd0;
    sw_state_d = sw_state_q;
    if (sw_s2_q != sw_state_q) begin
      if (db_cnt_q == DB_LAST) sw_state_d = sw_s2_q;
      else db_cnt_d = db_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      db_cnt_q   <= '0;
      sw_state_q <= 1'b0;
    end else begin
      db_cnt_q   <= db_cnt_d;
      sw_state_q <= sw_state_d;
    end
  end

  assign sw_state = sw_state_q;
`else
  assign sw_state = sw_s2_q;
`endif

  pwm_channel #(.PWM_BITS(PWM_BITS)) u_pwm_r (
    .clk(clk), .reset(reset), .pwm_cnt(pwm_cnt_q), .pwm_wrap(pwm_wrap),
    .duty_wr_en(be[2]), .duty_wdata(wlane[16 +: PWM_BITS]),
    .duty_shadow(r_shadow), .pin_n(RGB_R)
  );

  pwm_channel #(.PWM_BITS(PWM_BITS)) u_pwm_g (
    .clk(clk), .reset(reset), .pwm_cnt(pwm_cnt_q), .pwm_wrap(pwm_wrap),
    .duty_wr_en(be[1]), .duty_wdata(wlane[8 +: PWM_BITS]),
    .duty_shadow(g_shadow), .pin_n(RGB_G)
  );

  pwm_channel #(.PWM_BITS(PWM_BITS)) u_pwm_b (
    .clk(clk), .reset(reset), .pwm_cnt(pwm_cnt_q), .pwm_wrap(pwm_wrap),
    .duty_wr_en(be[0]), .duty_wdata(wlane[0 +: PWM_BITS]),
    .duty_shadow(b_shadow), .pin_n(RGB_B)
  );

  logic unused_bits;
  assign unused_bits = ^{wlane[31:25], rshift[31:16]};

  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign LED         = led_q;

endmodule

// File: tb/tb_mmio_responder.sv
// Directed bench for mmio_responder: register map, load extension, PWM duty, timebase and switch path.
// Bus tasks are entered and left just after a falling edge; each access takes exactly one cycle.
module tb_mmio_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [2:0]  funct3;
  logic        wr_en, rd_en;
  logic [31:0] wdata, rdata;
  logic        rdata_valid;
  logic        sw_pin, LED, RGB_R, RGB_G, RGB_B;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mmio_responder #(.CLK_HZ(12_000_000), .PWM_BITS(8)) dut (
    .clk(clk), .reset(reset), .addr(addr), .funct3(funct3),
    .wr_en(wr_en), .rd_en(rd_en), .wdata(wdata),
    .rdata(rdata), .rdata_valid(rdata_valid),
    .SW(sw_pin), .LED(LED), .RGB_R(RGB_R), .RGB_G(RGB_G), .RGB_B(RGB_B)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d);
    addr = a; funct3 = f3; wdata = d; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [2:0] f3, output logic [31:0] d);
    addr = a; funct3 = f3; rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    d = rdata;
    check_eq("rd_valid", {31'b0, rdata_valid}, 32'd1);
  endtask

  logic [31:0] v, us0, ms0, us1, ms1;
  int r_low, g_low, b_low;
  bit found;

  initial begin
    reset = 1'b1; addr = '0; funct3 = '0; wr_en = 1'b0; rd_en = 1'b0; wdata = '0; sw_pin = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_led",   {31'b0, LED},         32'd0);
    check_eq("rst_rgb_r", {31'b0, RGB_R},       32'd1);
    check_eq("rst_rgb_g", {31'b0, RGB_G},       32'd1);
    check_eq("rst_rgb_b", {31'b0, RGB_B},       32'd1);
    check_eq("rst_vld",   {31'b0, rdata_valid}, 32'd0);
    check_eq("rst_rdata", rdata,                32'd0);
    reset = 1'b0;

    load(32'hFFFF_FFF8, 3'd2, v);
    check_eq("micros_after_rst_le1", {31'b0, (v <= 32'd1)}, 32'd1);

    // LED on, R=0xFF, G=0x80, B=0x00
    store(32'hFFFF_FFFC, 3'd2, 32'h01FF_8000);
    check_eq("led_on", {31'b0, LED}, 32'd1);
    repeat (260) @(negedge clk);
    r_low = 0; g_low = 0; b_low = 0;
    for (int i = 0; i < 256; i++) begin
      if (!RGB_R) r_low++;
      if (!RGB_G) g_low++;
      if (!RGB_B) b_low++;
      @(negedge clk);
    end
    check_eq("pwm_r_low", 32'(r_low), 32'd255);
    check_eq("pwm_g_low", 32'(g_low), 32'd128);
    check_eq("pwm_b_low", 32'(b_low), 32'd0);
    load(32'hFFFF_FFFC, 3'd2, v);
    check_eq("lw_led_rgb", v, 32'h01FF_8000);
    @(negedge clk);
    check_eq("rdata_hold", rdata, 32'h01FF_8000);
    check_eq("vld_drop",   {31'b0, rdata_valid}, 32'd0);

    // Byte lanes and sign/zero extension
    store(32'hFFFF_FFFD, 3'd0, 32'h0000_0040);
    load(32'hFFFF_FFFD, 3'd0, v);  check_eq("lb_40",  v, 32'h0000_0040);
    store(32'hFFFF_FFFD, 3'd0, 32'h0000_0080);
    load(32'hFFFF_FFFD, 3'd0, v);  check_eq("lb_80",  v, 32'hFFFF_FF80);
    load(32'hFFFF_FFFD, 3'd4, v);  check_eq("lbu_80", v, 32'h0000_0080);
    store(32'hFFFF_FFFD, 3'd1, 32'h0000_ABCD);
    load(32'hFFFF_FFFC, 3'd2, v);  check_eq("sh_misaligned_dropped", v, 32'h01FF_8000);
    load(32'hFFFF_FFFC, 3'd1, v);  check_eq("lh_sext",  v, 32'hFFFF_8000);
    load(32'hFFFF_FFFC, 3'd5, v);  check_eq("lhu_zext", v, 32'h0000_8000);
    load(32'hFFFF_FFFE, 3'd1, v);  check_eq("lh_upper", v, 32'h0000_01FF);
    load(32'hFFFF_FFFD, 3'd1, v);  check_eq("lh_misaligned", v, 32'h0);
    load(32'hFFFF_FFFE, 3'd2, v);  check_eq("lw_misaligned", v, 32'h0);
    load(32'h0000_0010, 3'd2, v);  check_eq("unmapped_read", v, 32'h0);
    store(32'hFFFF_FFF8, 3'd2, 32'h1234_5678);
    load(32'hFFFF_FFF8, 3'd2, v);
    check_eq("micros_ro", {31'b0, (v == 32'h1234_5678)}, 32'd0);

    // 12000 cycles between samples: exactly 1000 us and 1 ms
    load(32'hFFFF_FFF8, 3'd2, us0);
    load(32'hFFFF_FFF4, 3'd2, ms0);
    repeat (11998) @(negedge clk);
    load(32'hFFFF_FFF8, 3'd2, us1);
    load(32'hFFFF_FFF4, 3'd2, ms1);
    check_eq("micros_delta", us1 - us0, 32'd1000);
    check_eq("millis_delta", ms1 - ms0, 32'd1);

    force dut.micros_q = 32'hFFFF_FFFF;
    #1 release dut.micros_q;
    @(negedge clk);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      load(32'hFFFF_FFF8, 3'd2, v);
      if (v != 32'hFFFF_FFFF) found = 1'b1;
    end
    check_eq("micros_wrap_seen", {31'b0, found}, 32'd1);
    check_eq("micros_wrap_val",  v, 32'd0);

    // Same-cycle SB + LBU returns the pre-write lane
    store(32'hFFFF_FFFC, 3'd0, 32'h0000_0022);
    addr = 32'hFFFF_FFFC; funct3 = 3'd4; wdata = 32'h0000_0011; wr_en = 1'b1; rd_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
    check_eq("rw_same_old", rdata, 32'h0000_0022);
    load(32'hFFFF_FFFC, 3'd4, v);
    check_eq("rw_same_new", v, 32'h0000_0011);

    // Reset during a read drops it
    addr = 32'hFFFF_FFFC; funct3 = 3'd2; rd_en = 1'b1; reset = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    check_eq("rst_mid_vld",   {31'b0, rdata_valid}, 32'd0);
    check_eq("rst_mid_rdata", rdata, 32'd0);
    check_eq("rst_mid_led",   {31'b0, LED}, 32'd0);
    reset = 1'b0;
    repeat (6) @(negedge clk);

    // Switch: back-to-back reads while SW rises
    sw_pin = 1'b1; addr = 32'hFFFF_FFF0; funct3 = 3'd2; rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("sw_b2b_vld", {31'b0, rdata_valid}, 32'd1);
`ifdef MMIO_SW_DEBOUNCE_EN
      check_eq("sw_sync_db", rdata, 32'd0);
`else
      check_eq("sw_sync", rdata, (i == 2) ? 32'd1 : 32'd0);
`endif
    end
    rd_en = 1'b0;
`ifdef MMIO_SW_DEBOUNCE_EN
    repeat (11990) @(negedge clk);
    load(32'hFFFF_FFF0, 3'd2, v);  check_eq("db_not_yet", v, 32'd0);
    repeat (10) @(negedge clk);
    load(32'hFFFF_FFF0, 3'd2, v);  check_eq("db_settled", v, 32'd1);
    sw_pin = 1'b0;
    repeat (10) @(negedge clk);
    sw_pin = 1'b1;
    repeat (12100) @(negedge clk);
    load(32'hFFFF_FFF0, 3'd2, v);  check_eq("db_glitch_ignored", v, 32'd1);
`else
    load(32'hFFFF_FFF0, 3'd0, v);  check_eq("sw_lb", v, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
